fsm_start_ctrl: RTL and testbench
=================================

// Module: fsm_start_ctrl
// PURPOSE
//  Upstream launcher for the 4-state sequencing FSM (IDLE->FIRST->SECOND->LAST->IDLE).
//  - Accepts tagged requests over valid/ready and queues them.
//  - Issues a 1-cycle start_fsm pulse only when the FSM reports IDLE.
//  - Tracks the run and reports completion with the request tag.
//  - Flags an error if the FSM never acknowledges a start.
// PARAMETERS
//  ID_W         4   request tag width (>=1)
//  DEPTH        4   request queue depth (power of 2, >=2)
//  ACK_TIMEOUT  8   max cycles in WAIT_ACK before error (>=2)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  req_valid  in   1      request present
//  req_id     in   ID_W   request tag
//  req_ready  out  1      queue can accept (count < DEPTH)
//  cs_fsm     in   2      current state of downstream FSM (0 IDLE,1 FIRST,2 SECOND,3 LAST)
//  start_fsm  out  1      registered start pulse to FSM
//  busy       out  1      controller not in C_IDLE, or queue non-empty
//  done       out  1      1-cycle pulse: a run completed
//  done_id    out  ID_W   tag of completed run (valid with done)
//  ack_err    out  1      sticky: FSM failed to leave IDLE within ACK_TIMEOUT
//  err_clr    in   1      clears ack_err
//  q_count    out  $clog2(DEPTH)+1  queued requests
// BEHAVIOUR
//  Reset (async, any time, incl. mid-run): queue empty, state C_IDLE, start_fsm=0,
//   done=0, done_id=0, ack_err=0, busy=0, q_count=0. Released synchronously to clk.
//  Push: req_valid & req_ready at an edge. Pop: the cycle the launch decision is taken.
//   Push and pop in the same cycle: count unchanged. req_ready = q_count<DEPTH, combinational.
//   No push when full (ready=0). Pointers wrap modulo DEPTH.
//  Controller states:
//   C_IDLE:     if q non-empty & cs_fsm==IDLE -> pop head into active_id, start_fsm<=1, go C_WAIT_ACK.
//   C_WAIT_ACK: start_fsm<=0. cs_fsm==FIRST -> C_RUN.
//               Timer hits ACK_TIMEOUT -> ack_err<=1, drop run (no done), go C_IDLE.
//   C_RUN:      cs_fsm==LAST -> done<=1, done_id<=active_id, go C_IDLE.
//               cs_fsm==IDLE (FSM reset externally) -> go C_IDLE silently, no done.
//  start_fsm is exactly 1 cycle wide, never asserted outside C_IDLE->C_WAIT_ACK transition.
//  Latency: request accepted at edge t0, queue empty, FSM idle:
//   - start_fsm high in cycle t0+2
//   - FSM FIRST at t0+3, LAST at t0+5
//   - done high in cycle t0+6
//   - next start earliest t0+7.
//  Back-to-back launches: a run can only launch when cs_fsm==IDLE; never while FSM is mid-sequence.
//  err_clr and a new error in the same cycle: error wins (ack_err stays 1).
//  cs_fsm is sampled as-is (same clock domain); no synchroniser.
// STRUCTURE
//  Package fsm_pkg:
//   - fsm_state_t enum {IDLE=0,FIRST=1,SECOND=2,LAST=3}, shared with the sequencing FSM.
//   - ctrl_state_t enum {C_IDLE,C_WAIT_ACK,C_RUN}.
//  Sub-module sync_fifo #(WIDTH=ID_W, DEPTH):
//   - Ports: push/pop, full/empty, count, head data.
//   - Async active-low reset.
//  Remainder of the block: controller FSM, ack timer, output registers.
// TESTING (bench pairs this block with the sequencing FSM; ack-timeout cases drive cs_fsm from the bench)
//  1 Single req id=5, idle FSM, queue empty -> start_fsm high at t0+2 for 1 cycle; done & done_id=5 at t0+6.
//  2 Push ids 1,2,3,4 back-to-back -> req_ready drops at count=4; starts spaced 5 cycles; done_ids 1,2,3,4 in order.
//  3 Push id=7 while FSM held in SECOND -> no start until cs_fsm==IDLE; then start next cycle.
//  4 Bench holds cs_fsm=IDLE after start -> ack_err=1 after 8 cycles, no done.
//    Next queued req still launches; err_clr -> ack_err=0.
//  5 Push on same cycle as pop with count=2 -> q_count stays 2; tags preserved in order.
//  6 rst_n low during C_RUN (async, mid-cycle) -> all outputs 0 immediately, queue empty; no done after release.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared types for the four-state sequencing FSM and its start controller.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        LAST   = 2'd3
    } fsm_state_t;

    typedef enum logic [1:0] {
        C_IDLE     = 2'd0,
        C_WAIT_ACK = 2'd1,
        C_RUN      = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with a combinational head view and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr_q];
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fsm_start_ctrl.sv
// Queues tagged launch requests, starts the sequencing FSM only when it is IDLE,
// and reports completion (with tag) or a missing start acknowledge.
module fsm_start_ctrl
    import fsm_pkg::*;
#(
    parameter int ID_W        = 4,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic [ID_W-1:0]        req_id,
    output logic                   req_ready,
    input  logic [1:0]             cs_fsm,
    output logic                   start_fsm,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic                   ack_err,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int TW = $clog2(ACK_TIMEOUT);

    fsm_state_t      cs;
    ctrl_state_t     state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [ID_W-1:0] active_id_q, active_id_d;
    logic [ID_W-1:0] done_id_q, done_id_d;
    logic            start_q, start_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic            launch, err_set;
    logic            fifo_full, fifo_empty;
    logic [ID_W-1:0] fifo_head;

    assign cs = fsm_state_t'(cs_fsm);

    sync_fifo #(
        .WIDTH (ID_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .push_data (req_id),
        .pop       (launch),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (q_count)
    );

    assign req_ready = ~fifo_full;
    assign busy      = (state_q != C_IDLE) | ~fifo_empty;
    assign start_fsm = start_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign ack_err   = ack_err_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        active_id_d = active_id_q;
        done_id_d   = done_id_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        launch      = 1'b0;
        err_set     = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (!fifo_empty && cs == IDLE) begin
                    launch      = 1'b1;
                    active_id_d = fifo_head;
                    start_d     = 1'b1;
                    timer_d     = '0;
                    state_d     = C_WAIT_ACK;
                end
            end
            C_WAIT_ACK: begin
                // An acknowledge on the final allowed cycle still counts.
                if (cs == FIRST) begin
                    state_d = C_RUN;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = C_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            C_RUN: begin
                if (cs == LAST) begin
                    done_d    = 1'b1;
                    done_id_d = active_id_q;
                    state_d   = C_IDLE;
                end else if (cs == IDLE) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
        if (err_set)      ack_err_d = 1'b1;
        else if (err_clr) ack_err_d = 1'b0;
        else              ack_err_d = ack_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= C_IDLE;
            timer_q     <= '0;
            active_id_q <= '0;
            done_id_q   <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            active_id_q <= active_id_d;
            done_id_q   <= done_id_d;
            start_q     <= start_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
        end
    end

endmodule

// File: tb/tb_fsm_start_ctrl.sv
// Pairs the start controller with a behavioural sequencing FSM and checks every
// cycle against a queue-based reference model; directed cases pin the latencies.
module tb_fsm_start_ctrl;
    localparam int ID_W        = 4;
    localparam int DEPTH       = 4;
    localparam int ACK_TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            req_valid = 1'b0;
    logic [ID_W-1:0] req_id = '0;
    logic [1:0]      cs_fsm = 2'd0;
    logic            err_clr = 1'b0;
    logic            req_ready, start_fsm, busy, done, ack_err;
    logic [ID_W-1:0] done_id;
    logic [2:0]      q_count;

    fsm_start_ctrl #(.ID_W(ID_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id),
        .req_ready(req_ready), .cs_fsm(cs_fsm), .start_fsm(start_fsm), .busy(busy),
        .done(done), .done_id(done_id), .ack_err(ack_err), .err_clr(err_clr),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick_no = 0;

    // reference model: pending tags, the tag awaiting acknowledge, the tag running
    int mq[$];
    int ack_wait = -1;
    int run_tag = -1;
    int act_tag = 0;
    bit m_start = 0, m_done = 0, m_err = 0;
    int m_done_id = 0;

    bit s_valid = 0, s_clr = 0, s_rst_n = 0;
    int s_id = 0;

    // behavioural sequencing FSM (0 IDLE, 1 FIRST, 2 SECOND, 3 LAST)
    int fsm_st = 0, fsm_force = -1, prev_cs = 0, idle_begin_cyc = -2;
    bit last_start = 0, fsm_ignore = 0, rnd_fsm = 0;

    int start_cyc[$];
    int done_cyc[$];
    int done_ids[$];

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, tick_no + 1, got, want);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_logs();
        start_cyc.delete();
        done_cyc.delete();
        done_ids.delete();
    endtask

    task automatic model_reset();
        mq.delete();
        ack_wait = -1; run_tag = -1; act_tag = 0;
        m_start = 0; m_done = 0; m_err = 0; m_done_id = 0;
    endtask

    task automatic model_step(input bit v, input int id, input int cs, input bit clr);
        int  cnt0;
        bit  err_set;
        cnt0 = mq.size();
        err_set = 0;
        m_start = 0;
        m_done = 0;
        if (ack_wait >= 0) begin
            if (cs == 1) begin
                run_tag = act_tag;
                ack_wait = -1;
            end else if (ack_wait + 1 >= ACK_TIMEOUT) begin
                err_set = 1;
                ack_wait = -1;
            end else begin
                ack_wait++;
            end
        end else if (run_tag >= 0) begin
            if (cs == 3) begin
                m_done = 1;
                m_done_id = run_tag;
                run_tag = -1;
            end else if (cs == 0) begin
                run_tag = -1;
            end
        end else if (mq.size() > 0 && cs == 0) begin
            act_tag = mq.pop_front();
            m_start = 1;
            ack_wait = 0;
        end
        if (v && cnt0 < DEPTH) mq.push_back(id);
        if (err_set) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic fsm_next();
        case (fsm_st)
            0: if (last_start && !fsm_ignore && !(rnd_fsm && $urandom_range(7) == 0)) fsm_st = 1;
            1: fsm_st = (rnd_fsm && $urandom_range(31) == 0) ? 0 : 2;
            2: begin
                if (rnd_fsm && $urandom_range(31) == 0)     fsm_st = 0;
                else if (!(rnd_fsm && $urandom_range(3) == 0)) fsm_st = 3;
            end
            default: fsm_st = 0;
        endcase
        if (fsm_force >= 0) fsm_st = fsm_force;
    endtask

    task automatic tick();
        int exp_busy;
        fsm_next();
        last_start = start_fsm;
        if (fsm_st == 0 && prev_cs != 0 && idle_begin_cyc == -1) idle_begin_cyc = tick_no + 1;
        prev_cs = fsm_st;
        req_valid = s_valid;
        req_id = ID_W'(s_id);
        err_clr = s_clr;
        cs_fsm = 2'(fsm_st);
        rst_n = s_rst_n;
        if (!s_rst_n) model_reset();
        else model_step(s_valid, s_id, fsm_st, s_clr);
        @(negedge clk);
        tick_no++;
        exp_busy = (ack_wait >= 0 || run_tag >= 0 || mq.size() > 0) ? 1 : 0;
        check("req_ready", int'(req_ready), (mq.size() < DEPTH) ? 1 : 0);
        check("q_count", int'(q_count), mq.size());
        check("start_fsm", int'(start_fsm), int'(m_start));
        check("busy", int'(busy), exp_busy);
        check("done", int'(done), int'(m_done));
        check("done_id", int'(done_id), m_done_id);
        check("ack_err", int'(ack_err), int'(m_err));
        if (start_fsm) start_cyc.push_back(tick_no + 1);
        if (done) begin
            done_cyc.push_back(tick_no + 1);
            done_ids.push_back(int'(done_id));
            $display("done id=%0d cycle=%0d", done_id, tick_no + 1);
        end
    endtask

    task automatic push_one(input int id);
        s_valid = 1; s_id = id;
        tick();
        s_valid = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", tick_no + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, err_cyc;
        bit seen;
        #1;
        rst_n = 1'b0;
        s_rst_n = 0;
        repeat (3) tick();
        s_rst_n = 1;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_q_count", int'(q_count), 0);
        check("rst_ack_err", int'(ack_err), 0);
        check("rst_done_id", int'(done_id), 0);

        // single request into an idle FSM
        clear_logs();
        push_one(5);
        t0 = tick_no;
        repeat (10) tick();
        check("t1_start_cycle", qget(start_cyc, 0), t0 + 2);
        check("t1_start_count", start_cyc.size(), 1);
        check("t1_done_cycle", qget(done_cyc, 0), t0 + 6);
        check("t1_done_id", qget(done_ids, 0), 5);

        // fill the queue while the FSM is busy, then drain back-to-back
        clear_logs();
        fsm_force = 3;
        for (int i = 1; i <= 5; i++) begin
            push_one(i);
            if (i == 4) begin
                check("t2_ready_full", int'(req_ready), 0);
                check("t2_count_full", int'(q_count), 4);
            end
        end
        fsm_force = 0;
        tick();
        fsm_force = -1;
        repeat (30) tick();
        check("t2_done_count", done_ids.size(), 4);
        for (int i = 0; i < 4; i++) check("t2_done_order", qget(done_ids, i), i + 1);
        for (int i = 0; i < 3; i++) check("t2_start_gap", qget(start_cyc, i + 1) - qget(start_cyc, i), 5);

        // request while the FSM is mid-sequence
        clear_logs();
        fsm_force = 2;
        push_one(7);
        repeat (5) tick();
        check("t3_no_start", start_cyc.size(), 0);
        check("t3_queued", int'(q_count), 1);
        fsm_force = -1;
        idle_begin_cyc = -1;
        repeat (12) tick();
        check("t3_start_after_idle", qget(start_cyc, 0), idle_begin_cyc + 1);
        check("t3_done_id", qget(done_ids, 0), 7);
        idle_begin_cyc = -2;

        // FSM never acknowledges: timeout, then the next tag still runs
        clear_logs();
        fsm_ignore = 1;
        push_one(3);
        t0 = tick_no;
        push_one(6);
        err_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ack_err) begin
                err_cyc = tick_no + 1;
                break;
            end
        end
        check("t4_err_cycle", err_cyc, t0 + 10);
        fsm_ignore = 0;
        repeat (12) tick();
        check("t4_done_count", done_ids.size(), 1);
        check("t4_done_id", qget(done_ids, 0), 6);
        check("t4_err_sticky", int'(ack_err), 1);
        s_clr = 1;
        tick();
        s_clr = 0;
        check("t4_err_cleared", int'(ack_err), 0);

        // clear held high while a new timeout fires: the error still shows
        clear_logs();
        fsm_ignore = 1;
        s_clr = 1;
        push_one(2);
        seen = 0;
        repeat (14) begin
            tick();
            if (ack_err) seen = 1;
        end
        check("t4b_err_wins", int'(seen), 1);
        fsm_ignore = 0;
        repeat (2) tick();
        s_clr = 0;
        check("t4b_err_low", int'(ack_err), 0);
        check("t4b_no_done", done_ids.size(), 0);

        // push on the same edge as a pop with two entries queued
        clear_logs();
        fsm_force = 2;
        push_one(8);
        push_one(9);
        check("t5_count_before", int'(q_count), 2);
        fsm_force = 0;
        push_one(10);
        check("t5_count_same", int'(q_count), 2);
        fsm_force = -1;
        repeat (24) tick();
        check("t5_done_count", done_ids.size(), 3);
        for (int i = 0; i < 3; i++) check("t5_done_order", qget(done_ids, i), i + 8);

        // asynchronous reset mid-run
        clear_logs();
        push_one(11);
        repeat (4) tick();
        check("t6_busy_before", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_start_zero", int'(start_fsm), 0);
        check("t6_busy_zero", int'(busy), 0);
        check("t6_done_zero", int'(done), 0);
        check("t6_done_id_zero", int'(done_id), 0);
        check("t6_count_zero", int'(q_count), 0);
        check("t6_err_zero", int'(ack_err), 0);
        s_rst_n = 0;
        model_reset();
        repeat (3) tick();
        s_rst_n = 1;
        repeat (10) tick();
        check("t6_no_done", done_ids.size(), 0);
        check("t6_done_id_after", int'(done_id), 0);

        // randomized traffic with a misbehaving FSM
        rnd_fsm = 1;
        for (int n = 0; n < 3000; n++) begin
            s_valid = ($urandom_range(9) < 4);
            s_id = $urandom_range(15);
            s_clr = ($urandom_range(19) == 0);
            if ($urandom_range(499) == 0) begin
                #2;
                rst_n = 1'b0;
                s_rst_n = 0;
                tick();
                s_rst_n = 1;
            end
            tick();
        end
        rnd_fsm = 0;
        s_valid = 0;
        s_clr = 0;
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
